// File: rtl/dmem_port_arb_pkg.sv
// Shared constants for the data-memory port arbiter: width, func3 codes,
// return-tag encodings and the access legality check.
package dmem_port_arb_pkg;

    localparam int DMEM_XLEN = 32;

    // Load/store func3 codes (loads and stores share encodings).
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Owner of the word arriving on the RAM read bus this cycle.
    localparam logic [1:0] R_NONE = 2'd0;
    localparam logic [1:0] R_IF   = 2'd1;
    localparam logic [1:0] R_LD   = 2'd2;
    localparam logic [1:0] R_RMW  = 2'd3;

    // True for a misaligned access or an undefined func3; both are
    // answered immediately without touching the RAM.
    function automatic logic is_bad_access(input logic       we,
                                           input logic [2:0] func3,
                                           input logic [1:0] offset);
        logic bad;
        if (we) begin
            case (func3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = offset[0];
                F3_SW:   bad = |offset;
                default: bad = 1'b1;
            endcase
        end else begin
            case (func3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = offset[0];
                F3_LW:         bad = |offset;
                default:       bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/dmem_port_arb_if.sv
// Bundle of the fetch, MEM-stage and RAM signals around the arbiter.
// Signal suffixes are from the arbiter's point of view.
interface dmem_port_arb_if #(parameter int XLEN = dmem_port_arb_pkg::DMEM_XLEN);

    // Instruction fetch
    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;

    // MEM pipeline stage
    logic            mem_re_i;
    logic            mem_we_i;
    logic [XLEN-1:0] mem_addr_i;
    logic [XLEN-1:0] mem_wdata_i;
    logic [2:0]      mem_func3_i;
    logic [XLEN-1:0] mem_rdata_o;
    logic            mem_done_o;
    logic            mem_misalign_o;
    logic            stall_o;

    // Single-port RAM
    logic [XLEN-1:0] ram_addr_o;
    logic            ram_we_o;
    logic [XLEN-1:0] ram_wdata_o;
    logic [XLEN-1:0] ram_rdata_i;

    // Arbiter side.
    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_re_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_func3_i,
        input  ram_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output mem_rdata_o, mem_done_o, mem_misalign_o, stall_o,
        output ram_addr_o, ram_we_o, ram_wdata_o
    );

    // Requester and RAM side.
    modport master (
        output if_req_i, if_addr_i,
        output mem_re_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_func3_i,
        output ram_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  mem_rdata_o, mem_done_o, mem_misalign_o, stall_o,
        input  ram_addr_o, ram_we_o, ram_wdata_o
    );

endinterface

// File: rtl/dmem_store_merge.sv
// Combinational byte/half lane merge for memories without byte enables.
module dmem_store_merge
    import dmem_port_arb_pkg::*;
#(
    parameter int XLEN = DMEM_XLEN
) (
    input  logic [XLEN-1:0] old_word_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [2:0]      func3_i,
    input  logic [1:0]      offset_i,
    output logic [XLEN-1:0] merged_o
);

    // Replace the addressed lane of the old word with right-justified store data.
    always_comb begin
        merged_o = old_word_i;
        case (func3_i)
            F3_SB:   merged_o[{offset_i, 3'b000} +: 8]     = wdata_i[7:0];
            F3_SH:   merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            F3_SW:   merged_o = wdata_i;
            default: merged_o = old_word_i;
        endcase
    end

endmodule

// File: rtl/dmem_port_arb.sv
// Shares one 1-cycle-latency single-port RAM between instruction fetch and
// the MEM stage; SB/SH become read-modify-write, MEM has priority over IF.
module dmem_port_arb
    import dmem_port_arb_pkg::*;
#(
    parameter int XLEN = DMEM_XLEN
) (
    input logic             clk_i,
    input logic             rst_i,
    dmem_port_arb_if.slave  bus
);

    logic [1:0]      ret_q, ret_d;
    logic [XLEN-1:0] held_addr_q, held_addr_d;
    logic [XLEN-1:0] held_wdata_q, held_wdata_d;
    logic [2:0]      held_func3_q, held_func3_d;

    logic            mem_req, mem_bad;
    logic [XLEN-1:0] if_word_addr, mem_word_addr, held_word_addr, merged_word;

    logic            ram_we, if_gnt, if_rvalid, mem_done, mem_misalign;
    logic [XLEN-1:0] ram_addr, ram_wdata, if_rdata, mem_rdata;

    assign mem_req        = bus.mem_re_i | bus.mem_we_i;
    assign mem_bad        = is_bad_access(bus.mem_we_i, bus.mem_func3_i, bus.mem_addr_i[1:0]);
    assign if_word_addr   = {bus.if_addr_i[XLEN-1:2], 2'b00};
    assign mem_word_addr  = {bus.mem_addr_i[XLEN-1:2], 2'b00};
    assign held_word_addr = {held_addr_q[XLEN-1:2], 2'b00};

    dmem_store_merge #(.XLEN(XLEN)) u_store_merge (
        .old_word_i (bus.ram_rdata_i),
        .wdata_i    (held_wdata_q),
        .func3_i    (held_func3_q),
        .offset_i   (held_addr_q[1:0]),
        .merged_o   (merged_word)
    );

    // Route returning read data and pick the one RAM access for this cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        ret_d        = R_NONE;
        held_addr_d  = held_addr_q;
        held_wdata_d = held_wdata_q;
        held_func3_d = held_func3_q;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        if_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        if_rdata     = '0;
        mem_done     = 1'b0;
        mem_misalign = 1'b0;
        mem_rdata    = '0;

        if (ret_q == R_LD) begin
            mem_rdata = bus.ram_rdata_i;
            mem_done  = 1'b1;
        end
        if (ret_q == R_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = bus.ram_rdata_i;
        end

        if (ret_q == R_RMW) begin
            // Second half of SB/SH: write back the merged word.
            ram_we    = 1'b1;
            ram_addr  = held_word_addr;
            ram_wdata = merged_word;
            mem_done  = 1'b1;
        end else if (mem_req && ret_q != R_LD) begin
            if (mem_bad) begin
                mem_done     = 1'b1;
                mem_misalign = 1'b1;
            end else if (bus.mem_we_i && bus.mem_func3_i == F3_SW) begin
                ram_we    = 1'b1;
                ram_addr  = mem_word_addr;
                ram_wdata = bus.mem_wdata_i;
                mem_done  = 1'b1;
            end else if (bus.mem_we_i) begin
                ram_addr     = mem_word_addr;
                held_addr_d  = bus.mem_addr_i;
                held_wdata_d = bus.mem_wdata_i;
                held_func3_d = bus.mem_func3_i;
                ret_d        = R_RMW;
            end else begin
                ram_addr = mem_word_addr;
                ret_d    = R_LD;
            end
        end else if (bus.if_req_i) begin
            if_gnt   = 1'b1;
            ram_addr = if_word_addr;
            ret_d    = R_IF;
        end
    end

    // Return tag and RMW holding registers; reset drops any pending RMW write.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            ret_q        <= R_NONE;
            held_addr_q  <= '0;
            held_wdata_q <= '0;
            held_func3_q <= '0;
        end else begin
            ret_q        <= ret_d;
            held_addr_q  <= held_addr_d;
            held_wdata_q <= held_wdata_d;
            held_func3_q <= held_func3_d;
        end
    end

    // All outputs are forced low while reset is asserted.
    assign bus.ram_we_o       = ram_we & ~rst_i;
    assign bus.ram_addr_o     = rst_i ? '0 : ram_addr;
    assign bus.ram_wdata_o    = rst_i ? '0 : ram_wdata;
    assign bus.if_gnt_o       = if_gnt & ~rst_i;
    assign bus.if_rvalid_o    = if_rvalid & ~rst_i;
    assign bus.if_rdata_o     = rst_i ? '0 : if_rdata;
    assign bus.mem_done_o     = mem_done & ~rst_i;
    assign bus.mem_misalign_o = mem_misalign & ~rst_i;
    assign bus.mem_rdata_o    = rst_i ? '0 : mem_rdata;
    assign bus.stall_o        = mem_req & ~mem_done & ~rst_i;

endmodule
